// File: rtl/axi_st_d128_asym_link_ctrl_pkg.sv
// Shared types for the half-slave link bring-up sequencer.
package ll_link_ctrl_pkg;

  localparam int LL_TIMER_W = 16;

  typedef enum logic [2:0] {
    ST_IDLE       = 3'd0,
    ST_CFG        = 3'd1,
    ST_WAIT_PHY   = 3'd2,
    ST_SETTLE     = 3'd3,
    ST_WAIT_ALIGN = 3'd4,
    ST_TX_ON      = 3'd5,
    ST_UP         = 3'd6,
    ST_ERR        = 3'd7
  } link_state_e;

  typedef struct packed {
    logic       gen2;
    logic [7:0] dx;
    logic [7:0] dxz;
    logic [7:0] dyz;
  } link_cfg_t;

endpackage

// File: rtl/axi_st_d128_asym_link_ctrl_timer.sv
// Clear/enable saturating up-counter with a compare-to-limit flag.
module ll_link_timer
  import ll_link_ctrl_pkg::*;
#(
  parameter int W = LL_TIMER_W
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         clr_i,
  input  logic         en_i,
  input  logic [W-1:0] limit_i,
  output logic         sat_o,
  output logic         hit_o
);

  logic [W-1:0] cnt_q, cnt_d;

  assign sat_o = &cnt_q;
  assign hit_o = (cnt_q == limit_i);

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i)              cnt_d = '0;
    else if (en_i && !sat_o) cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) cnt_q <= '0;
    else         cnt_q <= cnt_d;
  end

endmodule

// File: rtl/axi_st_d128_asym_link_ctrl.sv
// Bring-up / recovery sequencer: PHY ready, settle, alignment, TX then RX online.
module axi_st_d128_asym_link_ctrl
  import ll_link_ctrl_pkg::*;
#(
  parameter logic [15:0] TIMEOUT_CYC    = 16'd1024,
  parameter logic [7:0]  SETTLE_CYC     = 8'd16,
  parameter logic [3:0]  MAX_RETRY      = 4'd3,
  parameter logic        ALIGN_REQUIRED = 1'b1
) (
  input  logic       clk_wr,
  input  logic       rst_wr_n,
  input  logic       link_enable,
  input  logic       phy_tx_ready,
  input  logic       phy_rx_ready,
  input  logic       align_done,
  input  logic       cfg_gen2_mode,
  input  logic [7:0] cfg_delay_x,
  input  logic [7:0] cfg_delay_xz,
  input  logic [7:0] cfg_delay_yz,
  output logic       tx_online,
  output logic       rx_online,
  output logic       m_gen2_mode,
  output logic [7:0] delay_x_value,
  output logic [7:0] delay_xz_value,
  output logic [7:0] delay_yz_value,
  output logic       link_up,
  output logic       link_err,
  output logic [3:0] retry_cnt,
  output logic [2:0] ctrl_state
);

  link_state_e           state_q, state_d;
  logic [3:0]            retry_q, retry_d;
  link_cfg_t             cfg_q;
  logic [LL_TIMER_W-1:0] tmr_lim;
  logic                  tmr_hit, tmr_sat, tmr_clr, tmr_en, tmr_done;
  logic                  both_rdy, retry_evt;

  assign both_rdy = phy_tx_ready & phy_rx_ready;
  assign tmr_done = tmr_hit | tmr_sat;
  assign tmr_en   = state_q inside {ST_WAIT_PHY, ST_SETTLE, ST_WAIT_ALIGN};
  // One timer serves both the settle window and the timeout window.
  assign tmr_lim  = (state_q == ST_SETTLE) ? LL_TIMER_W'(SETTLE_CYC) - LL_TIMER_W'(1)
                                           : TIMEOUT_CYC - 16'd1;

  always_comb begin
    state_d   = state_q;
    retry_evt = 1'b0;
    case (state_q)
      ST_IDLE:       if (link_enable) state_d = ST_CFG;
      ST_CFG:        state_d = ST_WAIT_PHY;
      ST_WAIT_PHY: begin
        if (both_rdy)      state_d   = ST_SETTLE;
        else if (tmr_done) retry_evt = 1'b1;
      end
      ST_SETTLE: begin
        if (!both_rdy)     state_d = ST_WAIT_PHY;
        else if (tmr_done) state_d = ALIGN_REQUIRED ? ST_WAIT_ALIGN : ST_TX_ON;
      end
      ST_WAIT_ALIGN: begin
        if (!both_rdy)       retry_evt = 1'b1;
        else if (align_done) state_d   = ST_TX_ON;
        else if (tmr_done)   retry_evt = 1'b1;
      end
      ST_TX_ON:      state_d = ST_UP;
      ST_UP:         if (!both_rdy || (ALIGN_REQUIRED && !align_done)) retry_evt = 1'b1;
      ST_ERR:        state_d = ST_ERR;
      default:       state_d = ST_IDLE;
    endcase
    if (retry_evt) state_d = (retry_q < MAX_RETRY) ? ST_WAIT_PHY : ST_ERR;
    if (!link_enable) state_d = ST_IDLE;
  end

  always_comb begin
    retry_d = retry_q;
    if (!link_enable || state_q == ST_CFG)
      retry_d = '0;
    else if (retry_evt && retry_q < MAX_RETRY && retry_q != 4'hF)
      retry_d = retry_q + 4'd1;
  end

  // A retry re-enters WAIT_PHY from WAIT_PHY, so it must restart the window too.
  assign tmr_clr = (state_d != state_q) | retry_evt;

  ll_link_timer #(.W(LL_TIMER_W)) u_timer (
    .clk_i   (clk_wr),
    .rst_ni  (rst_wr_n),
    .clr_i   (tmr_clr),
    .en_i    (tmr_en),
    .limit_i (tmr_lim),
    .sat_o   (tmr_sat),
    .hit_o   (tmr_hit)
  );

  always_ff @(posedge clk_wr) begin
    if (!rst_wr_n) begin
      state_q <= ST_IDLE;
      retry_q <= '0;
      cfg_q   <= '0;
    end else begin
      state_q <= state_d;
      retry_q <= retry_d;
      if (state_q == ST_CFG)
        cfg_q <= '{gen2: cfg_gen2_mode, dx: cfg_delay_x, dxz: cfg_delay_xz, dyz: cfg_delay_yz};
    end
  end

  assign tx_online      = (state_q == ST_TX_ON) || (state_q == ST_UP);
  assign rx_online      = (state_q == ST_UP);
  assign link_up        = (state_q == ST_UP);
  assign link_err       = (state_q == ST_ERR);
  assign retry_cnt      = retry_q;
  assign ctrl_state     = state_q;
  assign m_gen2_mode    = cfg_q.gen2;
  assign delay_x_value  = cfg_q.dx;
  assign delay_xz_value = cfg_q.dxz;
  assign delay_yz_value = cfg_q.dyz;

endmodule
